// File: rtl/hdmi_period_scheduler_if.sv
// Timing-generator / packet-assembler / TMDS-mode bundle of hdmi_period_scheduler.
// master drives cx/cy/packet_req; slave (the scheduler) drives the period selects.
interface hdmi_period_scheduler_if #(
  parameter int unsigned BIT_WIDTH  = 10,
  parameter int unsigned BIT_HEIGHT = 10
);
  logic [BIT_WIDTH-1:0]  cx;
  logic [BIT_HEIGHT-1:0] cy;
  logic                  packet_req;
  logic [2:0]            mode;
  logic [3:0]            ctl;
  logic                  packet_start;
  logic [4:0]            packet_pixel;
  logic                  island_active;

  modport master (
    output cx, cy, packet_req,
    input  mode, ctl, packet_start, packet_pixel, island_active
  );

  modport slave (
    input  cx, cy, packet_req,
    output mode, ctl, packet_start, packet_pixel, island_active
  );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer (control/preamble/guard/video/data island), latency 1.
// Define DATA_ISLAND_EN for HDMI data islands; undefined gives a DVI-only build.
module hdmi_period_scheduler #(
  parameter int unsigned BIT_WIDTH      = 10,
  parameter int unsigned BIT_HEIGHT     = 10,
  parameter int unsigned SCREEN_START_X = 160,
  parameter int unsigned SCREEN_START_Y = 45,
  parameter int unsigned MAX_PACKETS    = 18
) (
  input  logic                   clk_pixel,
  input  logic                   reset_n,
  hdmi_period_scheduler_if.slave bus
);

  localparam int unsigned VP = SCREEN_START_X - 10;

  if (SCREEN_START_X < 60) begin : g_bad_start_x
    $error("SCREEN_START_X must be >= 60");
  end
  if ((MAX_PACKETS < 1) || (MAX_PACKETS > 18)) begin : g_bad_max_packets
    $error("MAX_PACKETS must be within 1..18");
  end

`ifdef DATA_ISLAND_EN
  localparam int unsigned LIMIT   = SCREEN_START_X - 14;
  localparam logic [4:0]  PKT_MAX = 5'(MAX_PACKETS);

  typedef enum logic [2:0] {
    S_CTRL, S_VID_PRE, S_VID_GUARD, S_VIDEO,
    S_ISL_PRE, S_ISL_GUARD_L, S_ISL_DATA, S_ISL_GUARD_T
  } state_t;
`else
  typedef enum logic [1:0] {S_CTRL, S_VID_PRE, S_VID_GUARD, S_VIDEO} state_t;
`endif

  logic [BIT_WIDTH-1:0]  cx;
  logic [BIT_HEIGHT-1:0] cy;
  logic                  at_vp;

  assign cx    = bus.cx;
  assign cy    = bus.cy;
  assign at_vp = (32'(cy) >= SCREEN_START_Y) && (32'(cx) == VP);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0] mode_q, mode_d;
  logic [3:0] ctl_q, ctl_d;

  assign cnt_inc = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;

`ifdef DATA_ISLAND_EN
  logic [4:0] pkt_q, pkt_d, pkt_inc, pixel_q, pixel_d;
  logic       cont_q, cont_d, start_q, start_d, active_q, active_d;
  logic       island_ok, room_next;

  assign pkt_inc = (pkt_q == 5'd31) ? pkt_q : pkt_q + 5'd1;
  // An island must fit preamble, guards, one packet and 4 control pixels before VP.
  assign island_ok = bus.packet_req && (32'(cx) >= 32'd4) && (32'(cx) + 32'd44 <= LIMIT);
  assign room_next = (32'(cx) + 32'd35) <= LIMIT;
`else
  logic unused_packet_req;
  assign unused_packet_req = bus.packet_req;
`endif

  // Next state for the pixel at the current cx/cy, from the previous pixel's state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
`ifdef DATA_ISLAND_EN
    pkt_d   = pkt_q;
    cont_d  = cont_q;
`endif
    unique case (state_q)
      S_CTRL: begin
        cnt_d = '0;
`ifdef DATA_ISLAND_EN
        if (island_ok) state_d = S_ISL_PRE;
`endif
      end
      S_VID_PRE: if (cnt_q == 5'd7) begin
        state_d = S_VID_GUARD;
        cnt_d   = '0;
      end
      S_VID_GUARD: if (cnt_q == 5'd1) begin
        state_d = S_VIDEO;
        cnt_d   = '0;
      end
      S_VIDEO: begin
        cnt_d = '0;
        if (cx == '0) state_d = S_CTRL;
      end
`ifdef DATA_ISLAND_EN
      S_ISL_PRE: if (cnt_q == 5'd7) begin
        state_d = S_ISL_GUARD_L;
        cnt_d   = '0;
      end
      S_ISL_GUARD_L: if (cnt_q == 5'd1) begin
        state_d = S_ISL_DATA;
        cnt_d   = '0;
        pkt_d   = 5'd1;
      end
      S_ISL_DATA: if (cnt_q == 5'd31) begin
        cnt_d = '0;
        if (cont_q) pkt_d = pkt_inc;
        else        state_d = S_ISL_GUARD_T;
      end
      S_ISL_GUARD_T: if (cnt_q == 5'd1) begin
        state_d = S_CTRL;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = S_CTRL;
        cnt_d   = '0;
      end
    endcase
`ifdef DATA_ISLAND_EN
    // Continuation is judged on the last pixel of each packet, with that pixel's cx.
    if ((state_d == S_ISL_DATA) && (cnt_d == 5'd31))
      cont_d = bus.packet_req && (pkt_d < PKT_MAX) && room_next;
`endif
    if (at_vp) begin
      state_d = S_VID_PRE;
      cnt_d   = '0;
    end
  end

  // Period selects for the pixel being scheduled.
  always_comb begin
    mode_d = 3'd0;
    ctl_d  = 4'd0;
`ifdef DATA_ISLAND_EN
    start_d  = 1'b0;
    pixel_d  = 5'd0;
    active_d = 1'b0;
`endif
    unique case (state_d)
      S_VID_PRE:   ctl_d  = 4'b0001;
      S_VID_GUARD: mode_d = 3'd2;
      S_VIDEO:     mode_d = 3'd1;
`ifdef DATA_ISLAND_EN
      S_ISL_PRE: begin
        ctl_d    = 4'b0101;
        active_d = 1'b1;
      end
      S_ISL_GUARD_L, S_ISL_GUARD_T: begin
        mode_d   = 3'd4;
        active_d = 1'b1;
      end
      S_ISL_DATA: begin
        mode_d   = 3'd3;
        start_d  = (cnt_d == 5'd0);
        pixel_d  = cnt_d;
        active_d = 1'b1;
      end
`endif
      default: mode_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CTRL;
      cnt_q   <= '0;
      mode_q  <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ctl_q   <= ctl_d;
    end
  end

`ifdef DATA_ISLAND_EN
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q    <= '0;
      cont_q   <= 1'b0;
      start_q  <= 1'b0;
      pixel_q  <= '0;
      active_q <= 1'b0;
    end else begin
      pkt_q    <= pkt_d;
      cont_q   <= cont_d;
      start_q  <= start_d;
      pixel_q  <= pixel_d;
      active_q <= active_d;
    end
  end

  assign bus.packet_start  = start_q;
  assign bus.packet_pixel  = pixel_q;
  assign bus.island_active = active_q;
`else
  assign bus.packet_start  = 1'b0;
  assign bus.packet_pixel  = 5'd0;
  assign bus.island_active = 1'b0;
`endif

  assign bus.mode = mode_q;
  assign bus.ctl  = ctl_q;

endmodule
